// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master to 1-slave memory bus arbiter.
// A grant is held for a whole access/ack transaction. Arbitration is either
// fixed priority (master 0 highest) or rotating round-robin, set by ROUND_ROBIN.
// One idle cycle separates consecutive grants (bus turnaround).
// Optional watchdog: define ARB_TIMEOUT_EN to add a wait-state counter that
// force-acks a stalled transaction and raises a sticky timeout_err.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 16,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int BW = DATA_WIDTH / 8,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
    input  logic [NUM_MASTERS-1:0]            m_wr_en,
    input  logic [NUM_MASTERS*BW-1:0]         m_bytesel,
    input  logic [NUM_MASTERS-1:0]            m_io,
    input  logic [NUM_MASTERS-1:0]            m_access,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_data_in,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_data_out,
    output logic                              s_wr_en,
    output logic [BW-1:0]                     s_bytesel,
    output logic                              s_io,
    output logic                              s_access,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_data_in,
    output logic [GW-1:0]                     grant_id,
`ifdef ARB_TIMEOUT_EN
    output logic                              timeout_err,
`endif
    output logic                              busy
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t  state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] rr_next;
    logic [GW-1:0] sel_id;
    logic [GW-1:0] cand;
    logic          sel_valid;
    logic          tmo_fire;
    logic          done;

    // Per-master views of the flat request buses
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] data_a;
    logic [NUM_MASTERS-1:0][BW-1:0]         bsel_a;

    assign addr_a = m_addr;
    assign data_a = m_data_out;
    assign bsel_a = m_bytesel;

    // Priority scan starting at rr_ptr; rr_ptr stays 0 in fixed mode, so the
    // lowest requesting index wins there. Scanning downward lets the nearest
    // requester overwrite the farther ones.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (m_access[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Pointer moves to the master after the one just served
    assign rr_next = (grant_id == GW'(NUM_MASTERS - 1)) ? '0 : grant_id + GW'(1);

    // Transaction ends on a slave ack or a watchdog expiry
    assign done = s_ack || tmo_fire;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0] tmo_cnt;

    // A real ack in the expiry cycle wins over the forced one
    assign tmo_fire = (state == OWNED) && !s_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    // Wait-state counter, held clear while idle so each grant starts at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_fire) begin
            timeout_err <= 1'b1;
        end else if (!s_ack) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Grant FSM: registered owner, request strobe and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            s_access <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_id <= sel_id;
                        state    <= OWNED;
                        s_access <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                OWNED: begin
                    if (done) begin
                        state    <= IDLE;
                        s_access <= 1'b0;
                        busy     <= 1'b0;
                        if (ROUND_ROBIN != 0) rr_ptr <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave request fields follow the current owner combinationally
    assign s_addr     = addr_a[grant_id];
    assign s_data_out = data_a[grant_id];
    assign s_bytesel  = bsel_a[grant_id];
    assign s_wr_en    = m_wr_en[grant_id];
    assign s_io       = m_io[grant_id];

    // Ack routed to the owner only; slave ack while idle is dropped
    always_comb begin
        m_ack = '0;
        if ((state == OWNED) && done) m_ack[grant_id] = 1'b1;
    end

    // Read data broadcast; an expired watchdog returns all-ones
    assign m_data_in = tmo_fire ? '1 : s_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share
// all inputs; directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 19;
    localparam int DW  = 16;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;
    localparam int OW  = 1 + 1 + 2 + N + DW + AW + DW + 1 + BW + 1;

    logic clk, reset;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_data_out;
    logic [N-1:0]    m_wr_en, m_io, m_access;
    logic [N*BW-1:0] m_bytesel;
    logic            s_ack;
    logic [DW-1:0]   s_data_in;

    logic [N-1:0]  rr_m_ack, fx_m_ack;
    logic [DW-1:0] rr_m_data_in, fx_m_data_in, rr_s_data_out, fx_s_data_out;
    logic [AW-1:0] rr_s_addr, fx_s_addr;
    logic          rr_s_wr_en, fx_s_wr_en, rr_s_io, fx_s_io;
    logic [BW-1:0] rr_s_bytesel, fx_s_bytesel;
    logic          rr_s_access, fx_s_access, rr_busy, fx_busy;
    logic [1:0]    rr_grant_id, fx_grant_id;
    logic          rr_tmo, fx_tmo;

    int n_chk = 0;
    int n_pass = 0;

    mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TMO)) u_rr (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_io(m_io), .m_access(m_access),
        .m_ack(rr_m_ack), .m_data_in(rr_m_data_in), .s_addr(rr_s_addr),
        .s_data_out(rr_s_data_out), .s_wr_en(rr_s_wr_en), .s_bytesel(rr_s_bytesel),
        .s_io(rr_s_io), .s_access(rr_s_access), .s_ack(s_ack), .s_data_in(s_data_in),
        .grant_id(rr_grant_id),
`ifdef ARB_TIMEOUT_EN
        .timeout_err(rr_tmo),
`endif
        .busy(rr_busy));

    mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TMO)) u_fx (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_io(m_io), .m_access(m_access),
        .m_ack(fx_m_ack), .m_data_in(fx_m_data_in), .s_addr(fx_s_addr),
        .s_data_out(fx_s_data_out), .s_wr_en(fx_s_wr_en), .s_bytesel(fx_s_bytesel),
        .s_io(fx_s_io), .s_access(fx_s_access), .s_ack(s_ack), .s_data_in(s_data_in),
        .grant_id(fx_grant_id),
`ifdef ARB_TIMEOUT_EN
        .timeout_err(fx_tmo),
`endif
        .busy(fx_busy));

`ifndef ARB_TIMEOUT_EN
    assign rr_tmo = 1'b0;
    assign fx_tmo = 1'b0;
`endif

    logic [OW-1:0] rr_obs, fx_obs;
    assign rr_obs = {rr_s_access, rr_busy, rr_grant_id, rr_m_ack, rr_m_data_in,
                     rr_s_addr, rr_s_data_out, rr_s_wr_en, rr_s_bytesel, rr_s_io};
    assign fx_obs = {fx_s_access, fx_busy, fx_grant_id, fx_m_ack, fx_m_data_in,
                     fx_s_addr, fx_s_data_out, fx_s_wr_en, fx_s_bytesel, fx_s_io};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #2;
        reset = 1'b0; m_access = '0; s_ack = 1'b0;
        #4 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic we, input logic [BW-1:0] bs, input logic io);
        m_addr[i*AW +: AW]    = a;
        m_data_out[i*DW +: DW] = d;
        m_wr_en[i]            = we;
        m_bytesel[i*BW +: BW] = bs;
        m_io[i]               = io;
    endtask

    task automatic rand_fields;
        for (int i = 0; i < N; i++)
            set_master(i, AW'($urandom), DW'($urandom), 1'($urandom), BW'($urandom), 1'($urandom));
    endtask

    // Expected observation for an arbiter whose owner is 'own' (-1 idle) and
    // whose last granted master is 'last'
    function automatic logic [OW-1:0] exp_obs(input int own, input int last);
        logic [N-1:0] a;
        a = (own >= 0 && s_ack) ? N'(1 << own) : '0;
        return {own >= 0, own >= 0, 2'(last), a, s_data_in, m_addr[last*AW +: AW],
                m_data_out[last*DW +: DW], m_wr_en[last], m_bytesel[last*BW +: BW], m_io[last]};
    endfunction

    task automatic test_reset;
        reset = 1'b0; m_access = '0; s_ack = 1'b0; s_data_in = '0;
        m_addr = '0; m_data_out = '0; m_wr_en = '0; m_bytesel = '0; m_io = '0;
        #12;
        n_chk++; if ({rr_s_access, rr_busy, rr_m_ack, rr_grant_id, rr_tmo} !== '0)
            $display("FAIL reset_rr: got %h exp 0", {rr_s_access, rr_busy, rr_m_ack, rr_grant_id, rr_tmo}); else n_pass++;
        n_chk++; if ({fx_s_access, fx_busy, fx_m_ack, fx_grant_id, fx_tmo} !== '0)
            $display("FAIL reset_fx: got %h exp 0", {fx_s_access, fx_busy, fx_m_ack, fx_grant_id, fx_tmo}); else n_pass++;
        @(negedge clk); reset = 1'b1;
        tick;
        s_ack = 1'b1;
        @(negedge clk);
        n_chk++; if ({rr_s_access, rr_m_ack, fx_s_access, fx_m_ack} !== '0)
            $display("FAIL idle_ack_ignored: got %h exp 0", {rr_s_access, rr_m_ack, fx_s_access, fx_m_ack}); else n_pass++;
        s_ack = 1'b0;
    endtask

    task automatic test_single_read;
        int hi, acks, first, bad, owned_n;
        do_reset;
        rand_fields;
        set_master(1, 19'h12345, 16'h0, 1'b0, 2'b11, 1'b0);
        s_data_in = 16'hBEEF; s_ack = 1'b0; m_access = 4'b0010;
        hi = 0; acks = 0; first = -1; bad = 0; owned_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (rr_s_access) owned_n++;
            s_ack = rr_s_access && (owned_n == 4);
            @(negedge clk);
            if (rr_s_access) begin
                hi++;
                if (first < 0) first = c;
                if (rr_s_addr !== 19'h12345 || rr_busy !== 1'b1) bad++;
            end
            if (rr_m_ack !== '0) begin
                acks++;
                if (rr_m_ack !== 4'b0010 || rr_m_data_in !== 16'hBEEF) bad++;
            end
            if (fx_m_ack !== rr_m_ack || fx_s_access !== rr_s_access) bad++;
            tick;
            if (acks != 0) m_access = '0;
        end
        n_chk++; if (hi != 4) $display("FAIL read_access_cycles: got %0d exp 4", hi); else n_pass++;
        n_chk++; if (acks != 1) $display("FAIL read_ack_count: got %0d exp 1", acks); else n_pass++;
        n_chk++; if (first != 1) $display("FAIL read_latency: got %0d exp 1", first); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL read_fields: got %0d bad cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_rr_all;
        logic [9:0] seq_rr, seq_fx;
        int hi, adj, bad;
        logic prev;
        do_reset;
        rand_fields;
        m_access = 4'hF; s_ack = 1'b1; s_data_in = DW'($urandom);
        seq_rr = '0; seq_fx = '0; hi = 0; adj = 0; bad = 0; prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rr_s_access) begin
                seq_rr = {seq_rr[7:0], rr_grant_id};
                hi++;
                if (prev) adj++;
                if (rr_m_ack !== N'(1 << rr_grant_id)) bad++;
            end
            if (fx_s_access) seq_fx = {seq_fx[7:0], fx_grant_id};
            prev = rr_s_access;
            tick;
        end
        m_access = '0; s_ack = 1'b0;
        n_chk++; if (seq_rr !== 10'h06C) $display("FAIL rr_sequence: got %h exp 06c", seq_rr); else n_pass++;
        n_chk++; if (seq_fx !== 10'h000) $display("FAIL fixed_sequence: got %h exp 000", seq_fx); else n_pass++;
        n_chk++; if (hi != 5 || adj != 0) $display("FAIL rr_turnaround: got %0d grants %0d adjacent exp 5 0", hi, adj); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL rr_ack_onehot: got %0d bad exp 0", bad); else n_pass++;
    endtask

    task automatic test_fixed_starve;
        int g, bad;
        do_reset;
        rand_fields;
        m_access = 4'b0101; s_ack = 1'b1;
        g = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (fx_s_access) begin
                g++;
                if (fx_grant_id !== 2'd0 || fx_m_ack !== 4'b0001) bad++;
            end
            tick;
        end
        n_chk++; if (g != 4 || bad != 0) $display("FAIL fixed_starve: got %0d grants %0d bad exp 4 0", g, bad); else n_pass++;
        if (fx_s_access) tick;
        m_access = 4'b0100;
        tick;
        n_chk++; if ({fx_s_access, fx_grant_id} !== 3'b110)
            $display("FAIL fixed_low_wins: got %b exp 110", {fx_s_access, fx_grant_id}); else n_pass++;
        m_access = 4'b0101;
        tick; tick;
        n_chk++; if ({fx_s_access, fx_grant_id} !== 3'b100)
            $display("FAIL fixed_back_to_0: got %b exp 100", {fx_s_access, fx_grant_id}); else n_pass++;
        m_access = '0; s_ack = 1'b0;
    endtask

    task automatic test_write_fields;
        logic [40:0] exp;
        do_reset;
        rand_fields;
        set_master(0, 19'h00010, 16'hA5A5, 1'b1, 2'b01, 1'b1);
        exp = {19'h00010, 16'hA5A5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
        m_access = 4'b0001; s_ack = 1'b0;
        tick;
        n_chk++; if ({rr_s_addr, rr_s_data_out, rr_s_wr_en, rr_s_bytesel, rr_s_io, rr_s_access, rr_busy} !== exp)
            $display("FAIL write_fields_rr: got %h exp %h", {rr_s_addr, rr_s_data_out, rr_s_wr_en, rr_s_bytesel, rr_s_io, rr_s_access, rr_busy}, exp); else n_pass++;
        tick;
        n_chk++; if ({fx_s_addr, fx_s_data_out, fx_s_wr_en, fx_s_bytesel, fx_s_io, fx_s_access, fx_busy} !== exp)
            $display("FAIL write_fields_fx: got %h exp %h", {fx_s_addr, fx_s_data_out, fx_s_wr_en, fx_s_bytesel, fx_s_io, fx_s_access, fx_busy}, exp); else n_pass++;
        s_ack = 1'b1; s_data_in = 16'h5A5A;
        @(negedge clk);
        n_chk++; if ({rr_m_ack, rr_m_data_in} !== {4'b0001, 16'h5A5A})
            $display("FAIL write_ack: got %h exp 15a5a", {rr_m_ack, rr_m_data_in}); else n_pass++;
        tick;
        m_access = '0; s_ack = 1'b0;
        n_chk++; if ({rr_s_access, rr_busy, fx_s_access, fx_busy} !== 4'b0)
            $display("FAIL write_release: got %b exp 0000", {rr_s_access, rr_busy, fx_s_access, fx_busy}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        rand_fields;
        m_access = 4'b0100; s_ack = 1'b1;
        tick;
        tick;
        m_access = 4'b1000; s_ack = 1'b0;
        tick;
        s_ack = 1'b1;
        #1;
        n_chk++; if ({rr_s_access, rr_m_ack} !== 5'b11000)
            $display("FAIL pre_reset_owned: got %b exp 11000", {rr_s_access, rr_m_ack}); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if ({rr_s_access, rr_busy, rr_m_ack, fx_s_access, fx_busy, fx_m_ack} !== '0)
            $display("FAIL async_reset: got %h exp 0", {rr_s_access, rr_busy, rr_m_ack, fx_s_access, fx_busy, fx_m_ack}); else n_pass++;
        s_ack = 1'b0; m_access = '0;
        #2 reset = 1'b1;
        tick;
        m_access = 4'hF;
        tick;
        n_chk++; if ({rr_s_access, rr_grant_id} !== 3'b100)
            $display("FAIL ptr_after_reset: got %b exp 100", {rr_s_access, rr_grant_id}); else n_pass++;
        s_ack = 1'b1;
        tick;
        m_access = '0; s_ack = 1'b0;
        tick;
    endtask

    task automatic test_random;
        int own[2], last[2], wt[2];
        int ptr, p;
        logic [OW-1:0] e;
        do_reset;
        own = '{-1, -1}; last = '{0, 0}; wt = '{0, 0}; ptr = 0;
        for (int c = 0; c < 400; c++) begin
            rand_fields;
            for (int i = 0; i < N; i++)
                m_access[i] = (i == own[0] || i == own[1]) ? 1'b1 : ($urandom_range(0, 2) == 0);
            s_ack = ($urandom_range(0, 2) == 0) || wt[0] >= 5 || wt[1] >= 5;
            s_data_in = DW'($urandom);
            #1;
            e = exp_obs(own[0], last[0]);
            n_chk++; if (rr_obs !== e) $display("FAIL random_rr cycle %0d: got %h exp %h", c, rr_obs, e); else n_pass++;
            e = exp_obs(own[1], last[1]);
            n_chk++; if (fx_obs !== e) $display("FAIL random_fx cycle %0d: got %h exp %h", c, fx_obs, e); else n_pass++;
            for (int d = 0; d < 2; d++) begin
                if (own[d] < 0) begin
                    p = (d == 0) ? ptr : 0;
                    for (int k = 0; k < N; k++) begin
                        if (own[d] < 0 && m_access[(p + k) % N]) begin
                            own[d] = (p + k) % N;
                            last[d] = own[d];
                            wt[d] = 0;
                        end
                    end
                end else if (s_ack) begin
                    if (d == 0) ptr = (own[d] + 1) % N;
                    own[d] = -1;
                end else begin
                    wt[d]++;
                end
            end
            tick;
        end
        m_access = '0; s_ack = 1'b0;
        tick; tick;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int waits, acked, bad;
        do_reset;
        rand_fields;
        m_access = 4'b0010; s_ack = 1'b0; s_data_in = 16'h1234;
        waits = 0; acked = 0; bad = 0;
        for (int c = 0; c < 30 && acked == 0; c++) begin
            @(negedge clk);
            if (rr_m_ack !== '0) begin
                acked = 1;
                if (rr_m_ack !== 4'b0010 || rr_m_data_in !== 16'hFFFF || rr_tmo !== 1'b0) bad++;
            end else if (rr_s_access) begin
                waits++;
                if (rr_tmo !== 1'b0) bad++;
            end
            tick;
        end
        m_access = '0;
        n_chk++; if (acked != 1 || bad != 0) $display("FAIL tmo_forced_ack: got acked %0d bad %0d exp 1 0", acked, bad); else n_pass++;
        n_chk++; if (waits != TMO) $display("FAIL tmo_wait_cycles: got %0d exp %0d", waits, TMO); else n_pass++;
        tick; tick;
        n_chk++; if ({rr_tmo, fx_tmo, rr_s_access} !== 3'b110)
            $display("FAIL tmo_sticky: got %b exp 110", {rr_tmo, fx_tmo, rr_s_access}); else n_pass++;
        m_access = 4'b1000; s_ack = 1'b1; s_data_in = 16'h0F0F;
        tick;
        @(negedge clk);
        n_chk++; if ({rr_s_access, rr_grant_id, rr_m_ack, rr_m_data_in, rr_tmo} !== {1'b1, 2'd3, 4'b1000, 16'h0F0F, 1'b1})
            $display("FAIL tmo_next_served: got %h exp %h", {rr_s_access, rr_grant_id, rr_m_ack, rr_m_data_in, rr_tmo},
                     {1'b1, 2'd3, 4'b1000, 16'h0F0F, 1'b1}); else n_pass++;
        tick;
        m_access = '0; s_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single_read;
        test_rr_all;
        test_fixed_starve;
        test_write_fields;
        test_reset_mid;
        test_random;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master to 1-slave memory bus arbiter.
- Next-generation replacement for the fixed split between the instruction bus and the data bus at the core boundary: prefetch, load/store and future masters (DMA, debug) share one external memory port.
- Each master keeps the existing access/ack handshake unchanged.
- Grant is held for a whole transaction. Arbitration is fixed-priority or round-robin, chosen by parameter.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); master 0 is the highest priority in fixed mode.
- ADDR_WIDTH, 19, word-address width; addresses are bits [ADDR_WIDTH:1].
- DATA_WIDTH, 16, data bus width; byte-select width is DATA_WIDTH/8.
- ROUND_ROBIN, 1, 1 = rotating priority, 0 = fixed priority.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master word address, packed with master i at slice i
- m_data_out  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_wr_en  in  NUM_MASTERS  per-master write strobe
- m_bytesel  in  NUM_MASTERS*(DATA_WIDTH/8)  per-master byte selects
- m_io  in  NUM_MASTERS  per-master I/O-space flag
- m_access  in  NUM_MASTERS  per-master request, held until acked
- m_ack  out  NUM_MASTERS  per-master completion strobe, one-hot or zero
- m_data_in  out  DATA_WIDTH  read data, broadcast to all masters
- s_addr  out  ADDR_WIDTH  slave address
- s_data_out  out  DATA_WIDTH  slave write data
- s_wr_en  out  1  slave write strobe
- s_bytesel  out  DATA_WIDTH/8  slave byte selects
- s_io  out  1  slave I/O flag
- s_access  out  1  slave request
- s_ack  in  1  slave completion
- s_data_in  in  DATA_WIDTH  slave read data
- grant_id  out  $clog2(NUM_MASTERS) (min 1)  current owner, for debug
- busy  out  1  a transaction is in flight
- timeout_err  out  1  sticky watchdog error; only present with ARB_TIMEOUT_EN

Behaviour:
- Reset (reset low, takes effect asynchronously):
  - state=IDLE, grant_id=0, round-robin pointer=0.
  - s_access=0, busy=0, m_ack=0, timeout_err=0.
- FSM states: IDLE, OWNED.
- IDLE:
  - Priority selection over m_access happens at the clock edge.
  - Fixed mode: the lowest asserted index wins.
  - Round-robin mode: the search starts at the pointer and wraps modulo NUM_MASTERS.
  - If any master is requesting: register grant_id and go to OWNED.
  - If no master is requesting: stay in IDLE; outputs hold.
- OWNED:
  - s_access=1 and busy=1.
  - s_addr, s_data_out, s_wr_en, s_bytesel and s_io are combinationally muxed from master grant_id.
  - s_access stays 1 while s_ack is low; wait states are unbounded unless the watchdog fires.
- Acknowledge:
  - m_ack[grant_id]=s_ack in the same cycle; all other m_ack bits are 0.
  - m_data_in=s_data_in always, broadcast; qualified only by m_ack.
  - On the edge where s_ack=1: go to IDLE. In round-robin mode, pointer = (grant_id+1) mod NUM_MASTERS.
- Latency:
  - Request seen in idle cycle T → s_access high in cycle T+1.
  - Minimum transaction is 2 cycles (ack in cycle T+1).
  - After ack there is one IDLE cycle before the next grant (bus turnaround); no back-to-back grant.
- Master rules:
  - A master must drop m_access on the cycle after its ack, or hold it to start a new transaction.
  - A request withdrawn before grant is ignored.
  - A request withdrawn while owned is a protocol violation. The arbiter keeps the grant until s_ack; no X-propagation is required.
- s_ack while IDLE is ignored; no m_ack is generated.
- Simultaneous requests from every master: exactly one grant. Round-robin guarantees each master is served within NUM_MASTERS transactions.
- NUM_MASTERS=1 degenerates to a registered pass-through with grant_id=0.
- Reset mid-transaction: s_access drops immediately and the in-flight ack is lost. Masters are reset by the same signal.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on each grant and increments each OWNED cycle without s_ack.
  - When the count reaches TIMEOUT_CYCLES: force m_ack[grant_id]=1 with m_data_in=all-ones for one cycle, set timeout_err (sticky until reset), and go to IDLE.
- When undefined: no counter, no timeout_err port, and waits are unbounded.

Test Plan:
- Single master 1 requests addr 0x12345 read, slave acks after 3 wait cycles with data 0xBEEF → s_addr=0x12345, s_access high 4 cycles, m_ack[1] pulses once with m_data_in=0xBEEF; m_ack[0] stays 0.
- NUM_MASTERS=4, ROUND_ROBIN=1, all four hold access continuously, slave acks immediately → grant sequence 0,1,2,3,0, each with one idle cycle between grants.
- ROUND_ROBIN=0, masters 0 and 2 hold access continuously → master 0 granted every transaction, master 2 starved; one check cycle where master 0 drops → master 2 granted.
- Master 0 write addr 0x00010 data 0xA5A5 bytesel 2'b01 io=1 → slave sees identical s_* values while s_access high; s_wr_en=1, s_io=1.
- Reset asserted low in the middle of OWNED → s_access, busy and m_ack all 0 immediately without a clock; after release, a new request is served from IDLE with the pointer at 0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → forced m_ack with data 0xFFFF after 8 owned cycles, timeout_err=1 and stays high; the next request is still served.
